// File: rtl/pipe_pkg.sv
// Shared constants for the IF stage: next-PC select encodings, the NOP word
// and the default reset PC.
package pipe_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_REG    = 2'd2,
    PCSRC_JUMP   = 2'd3
  } pcsrc_e;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipe_if_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// imem_rdata is consumed only in a cycle where imem_ready=1; the master holds
// imem_addr until then unless it redirects.
interface pipe_if_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/pipe_if_if_id_reg.sv
// IF/ID pipeline register: holds on hold_i, loads a NOP bubble on bubble_i,
// otherwise captures the fetched word.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!hold_i) begin
      if (bubble_i) begin
        inst_d  = NOP_WORD;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end else begin
        inst_d  = inst_i;
        pc4_d   = pc4_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= NOP_WORD;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register and
// stall/wait-state counters.
module pipe_if
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  pipe_if_if.master   imem,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc4,
  output logic        ID_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] wait_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] pc4;
  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic        fetch_done;
  logic        bubble;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    npc_raw = pc4;
    case (pcsrc_e'(pcsource))
      PCSRC_BRANCH: npc_raw = bpc;
      PCSRC_REG:    npc_raw = rpc;
      PCSRC_JUMP:   npc_raw = jpc;
      default:      npc_raw = pc4;
    endcase
    npc = npc_raw & ~32'h0000_0003;
  end

  assign fetch_done = !wpcir && imem.imem_ready;
  assign bubble     = !wpcir && !imem.imem_ready;

  // A redirect during a wait abandons the pending fetch; a sequential wait keeps retrying.
  always_comb begin
    pc_d    = pc_q;
    stall_d = stall_q;
    wait_d  = wait_q;
    if (wpcir) begin
      stall_d = stall_q + 32'd1;
    end else begin
      if (!imem.imem_ready) begin
        wait_d = wait_q + 32'd1;
      end
      if (imem.imem_ready || (pcsrc_e'(pcsource) != PCSRC_SEQ)) begin
        pc_d = npc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      stall_q <= 32'h0000_0000;
      wait_q  <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i    (clock),
    .rst_i    (reset),
    .hold_i   (wpcir),
    .bubble_i (bubble),
    .inst_i   (imem.imem_rdata),
    .pc4_i    (pc4),
    .inst_o   (ID_inst),
    .pc4_o    (ID_pc4),
    .valid_o  (ID_valid)
  );

  assign imem.imem_addr = pc_q;
  assign stall_cnt      = stall_q;
  assign wait_cnt       = wait_q;

  logic unused_fetch_done;
  assign unused_fetch_done = fetch_done;

endmodule

// File: tb/tb_pipe_if.sv
// Bench for pipe_if: a reference model pushes the expected IF-stage state for
// each driven cycle; each scenario pops and compares after the clock edge.
module tb_pipe_if;
  import pipe_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] stall;
    logic [31:0] wcnt;
  } st_t;

  localparam int W = $bits(st_t);
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic [1:0]  pcsource;
  logic        wpcir;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] ID_inst, ID_pc4, stall_cnt, wait_cnt;
  logic        ID_valid;

  pipe_if_if bus ();

  pipe_if #(.RESET_PC(RST_PC)) dut (
    .clock     (clock),
    .reset     (reset),
    .pcsource  (pcsource),
    .wpcir     (wpcir),
    .bpc       (bpc),
    .rpc       (rpc),
    .jpc       (jpc),
    .imem      (bus.master),
    .ID_inst   (ID_inst),
    .ID_pc4    (ID_pc4),
    .ID_valid  (ID_valid),
    .stall_cnt (stall_cnt),
    .wait_cnt  (wait_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  st_t act;
  assign act = '{pc: bus.imem_addr, inst: ID_inst, pc4: ID_pc4, valid: ID_valid,
                 stall: stall_cnt, wcnt: wait_cnt};

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [W-1:0] exp_q[$];
  st_t m;
  st_t got;
  int  n_chk  = 0;
  int  n_fail = 0;

  // driver: applies one cycle of inputs and pushes the modelled next state
  task automatic drive_cycle(input logic rst, input logic wp, input logic rdy,
                             input logic [1:0] ps, input logic [31:0] b,
                             input logic [31:0] r, input logic [31:0] j);
    logic [31:0] npc;
    reset = rst; wpcir = wp; bus.imem_ready = rdy; pcsource = ps;
    bpc = b; rpc = r; jpc = j;
    case (ps)
      2'd0: npc = m.pc + 32'd4;
      2'd1: npc = b;
      2'd2: npc = r;
      default: npc = j;
    endcase
    npc[1:0] = 2'b00;
    if (rst) begin
      m = '{pc: RST_PC, inst: 32'h0, pc4: 32'h0, valid: 1'b0, stall: 32'h0, wcnt: 32'h0};
    end else if (wp) begin
      m.stall = m.stall + 32'd1;
    end else if (rdy) begin
      m.inst  = mem_word(m.pc);
      m.pc4   = m.pc + 32'd4;
      m.valid = 1'b1;
      m.pc    = npc;
    end else begin
      m.wcnt  = m.wcnt + 32'd1;
      if (ps != 2'd0) m.pc = npc;
      m.inst  = 32'h0;
      m.pc4   = 32'h0;
      m.valid = 1'b0;
    end
    exp_q.push_back(m);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h44, 32'h55, 32'h66);
    drive_cycle(1'b1, 1'b0, 1'b1, 2'd1, 32'h44, 32'h55, 32'h66);
    repeat (2) begin
      got = exp_q.pop_front();
      n_chk++;
      if (act !== got) begin
        n_fail++;
        $display("FAIL reset_state act=%h exp=%h", act, got);
      end
    end
    n_chk++;
    if (bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_addr act=%h exp=%h", bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want_pc4;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (bus.imem_addr !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL seq_addr[%0d] act=%h exp=%h", i, bus.imem_addr, 32'(i * 4));
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
      got = exp_q.pop_front();
      want_pc4 = 32'((i + 1) * 4);
      n_chk++;
      if (act !== got || ID_pc4 !== want_pc4 || ID_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d] act=%h exp=%h pc4 exp=%h", i, act, got, want_pc4);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_inst;
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_setup act=%h exp=%h", act, got);
    end
    held_inst = mem_word(32'hC);
    drive_cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h800, 32'h0, 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 32'h900);
    got = exp_q.pop_front();
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== 32'h10 || ID_inst !== held_inst || stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_hold act=%h exp=%h stall=%0d", act, got, stall_cnt);
    end
  endtask

  task automatic test_wait();
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd1, 32'h20, 32'h0, 32'h0);
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL wait_setup act=%h exp=%h", act, got);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
      got = exp_q.pop_front();
      n_chk++;
      if (act !== got || bus.imem_addr !== 32'h20 || ID_inst !== 32'h0 || ID_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold[%0d] act=%h exp=%h", i, act, got);
      end
    end
    n_chk++;
    if (wait_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL wait_cnt act=%0d exp=3", wait_cnt);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || ID_inst !== mem_word(32'h20) || ID_pc4 !== 32'h24) begin
      n_fail++;
      $display("FAIL wait_done act=%h exp=%h", act, got);
    end
  endtask

  task automatic test_redirect_wait();
    drive_cycle(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 32'h400);
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== 32'h400 || ID_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_wait act=%h exp=%h", act, got);
    end
  endtask

  task automatic test_jr_wrap();
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h103, 32'h0);
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL jr_align act=%h exp=%h", act, got);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
    got = exp_q.pop_front();
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || ID_pc4 !== 32'h0 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap act=%h exp=%h", act, got);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    drive_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 32'h700);
    repeat (2) void'(exp_q.pop_front());
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || bus.imem_addr !== RST_PC || stall_cnt !== 32'h0 || wait_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_stall act=%h exp=%h", act, got);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h300, 32'h0);
    void'(exp_q.pop_front());
    got = exp_q.pop_front();
    n_chk++;
    if (act !== got || wait_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_wait act=%h exp=%h", act, got);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
      got = exp_q.pop_front();
      n_chk++;
      if (act !== got) begin
        n_fail++;
        $display("FAIL random[%0d] act=%h exp=%h", i, act, got);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wpcir = 1'b0; pcsource = 2'd0;
    bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    bus.imem_ready = 1'b0;
    m = '0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_wait();
    test_redirect_wait();
    test_jr_wrap();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_if.md
PIPE_IF -- requirements
Module: pipe_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port pcsource  in  2  next-PC select from the ID control unit: 0 = PC+4, 1 = branch target, 2 = register target, 3 = jump target.
REQ-005 SHALL have port wpcir  in  1  load-use stall from the ID control unit; 1 = hold PC and IF/ID.
REQ-006 SHALL have ports bpc, rpc, jpc  in  32 each  branch target, jr register target and j/jal target, all computed in ID.
REQ-007 SHALL have port imem_addr  out  32  instruction address, equal to the PC register.
REQ-008 SHALL have ports imem_rdata  in  32  instruction word, and imem_ready  in  1  1 = imem_rdata is valid this cycle.
REQ-009 SHALL have ports ID_inst  out  32, ID_pc4  out  32, ID_valid  out  1: the IF/ID register contents.
REQ-010 SHALL have ports stall_cnt  out  32 and wait_cnt  out  32: counters of wpcir cycles and imem wait cycles.

Function
REQ-011 SHALL compute npc by pcsource: 0 -> pc+4, 1 -> bpc, 2 -> rpc, 3 -> jpc, with npc[1:0] forced to 2'b00.
REQ-012 SHALL, in a cycle with wpcir=1, hold pc, ID_inst, ID_pc4 and ID_valid unchanged, regardless of imem_ready and pcsource.
REQ-013 SHALL, in a cycle with wpcir=0 and imem_ready=1, load pc <= npc, ID_inst <= imem_rdata, ID_pc4 <= pc+4 and ID_valid <= 1.
REQ-014 SHALL, in a cycle with wpcir=0, imem_ready=0 and pcsource=0, hold pc and load ID_inst <= 32'h0000_0000 (nop), ID_pc4 <= 0 and ID_valid <= 0.
REQ-015 SHALL, in a cycle with wpcir=0, imem_ready=0 and pcsource!=0, load pc <= npc, abandon the pending fetch, and load the nop bubble into IF/ID as in REQ-014.
REQ-016 SHALL give fetch latency of one cycle: the word presented at imem_addr in cycle N appears on ID_inst in cycle N+1 when imem_ready=1 in cycle N.
REQ-017 SHALL NOT itself squash a fetched instruction on redirect; wrong-path squash is performed downstream by the ID bubble mechanism.
REQ-018 SHALL compute pc+4 modulo 2^32, so pc=32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 SHALL increment stall_cnt by 1 in every non-reset cycle with wpcir=1, and wait_cnt by 1 in every non-reset cycle with wpcir=0 and imem_ready=0; both wrap modulo 2^32.
REQ-020 SHALL drive all outputs directly from registers, except imem_addr, which is the pc register itself.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, set pc=RESET_PC, ID_inst=0, ID_pc4=0, ID_valid=0, stall_cnt=0 and wait_cnt=0.
REQ-022 SHALL give reset priority over wpcir, imem_ready and pcsource, including when reset is asserted mid-wait or mid-stall.
REQ-023 SHALL present imem_addr=RESET_PC in the first cycle after reset deasserts.

Structure
REQ-024 SHALL take the pcsource encodings, the NOP word and the default RESET_PC from the shared package pipe_pkg.
REQ-025 SHALL instantiate one sub-module, if_id_reg, holding ID_inst, ID_pc4 and ID_valid with hold and bubble-load controls.
REQ-026 SHALL keep the next-PC mux and the counters in pipe_if.

Verification
REQ-027 SHALL verify sequential fetch: reset, then imem_ready=1 and pcsource=0 for 3 cycles -> imem_addr 0,4,8 and ID_pc4 4,8,12 with ID_valid=1.
REQ-028 SHALL verify load-use stall: pc=0x10 and wpcir=1 for 2 cycles -> pc stays 0x10, ID_inst unchanged, stall_cnt=2.
REQ-029 SHALL verify wait state: imem_ready=0 for 3 cycles at pc=0x20 -> pc stays 0x20, ID_inst=0, ID_valid=0, wait_cnt=3; ready=1 -> fetch from 0x20 completes.
REQ-030 SHALL verify redirect during wait: imem_ready=0, pcsource=3, jpc=0x400 -> next pc=0x400 and ID_valid=0.
REQ-031 SHALL verify jr alignment and wrap: pcsource=2 with rpc=0x103 -> pc=0x100; pc=0xFFFF_FFFC with ready=1 -> ID_pc4=0 and next pc=0.
REQ-032 SHALL verify reset mid-stall: wpcir=1 and reset=1 in the same cycle -> pc=RESET_PC and both counters 0 on the next cycle.
